text_char_buffer: RTL and testbench
===================================

Name: text_char_buffer

Overview:
- Character-cell text buffer between the CPU data bus and the VGA character generator.
- Stores one 8-bit code per cell of a 128x32 grid; 70x30 cells are visible.
- Applies a vertical scroll offset (line_offset) on the display read path.
- Clears itself to a fill character after reset; optional cursor register and cursor-hit output.

Parameters:
- H_BITS, 7, column index width; storage is 2^H_BITS columns.
- V_BITS, 5, row index width; storage is 2^V_BITS rows.
- COLS, 70, visible columns; reads with rd_h >= COLS return FILL_CHAR.
- FILL_CHAR, 8'h20, code written by the post-reset clear and returned for out-of-range columns.

Ports:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- wr_en  in  1  CPU write strobe for the character region.
- wr_addr  in  12  bus address low bits: [6:0] column, [11:7] row.
- wr_data  in  8  character code to store.
- rd_h  in  7  display column being scanned.
- rd_v  in  5  display row being scanned.
- rd_data  out  8  character code for the scanned cell, registered.
- lo_we  in  1  line_offset write strobe.
- lo_data  in  5  new line_offset value.
- line_offset  out  5  current scroll offset.
- busy  out  1  clear in progress.

Behaviour:
- Internal RAM address = {col, row}, with column in the high 7 bits and row in the low 5 bits; depth 4096 x 8.
- Single-port RAM: one access per cycle.
- Arbitration when idle:
  - If wr_en=1, the cycle writes wr_data at {wr_addr[6:0], wr_addr[11:7]}; rd_data holds its previous value.
  - Otherwise the cycle reads at {rd_h, (rd_v + line_offset) mod 32}; rd_data is valid on the next clock (1-cycle latency).
- Row addition is a 5-bit wrap: rd_v=31, line_offset=3 -> physical row 2. Rows 30/31 are stored normally.
- If rd_h >= COLS, the registered result is FILL_CHAR regardless of RAM contents.
- line_offset is a register; when lo_we=1 it takes lo_data at the clock edge. The read issued in that same cycle uses the old offset. lo_we is accepted while busy.
- States: CLEAR and IDLE.
  - reset=1: state=CLEAR, clear counter=0, busy=1, rd_data=8'h00, line_offset=0.
  - In CLEAR with reset=0, each cycle writes FILL_CHAR at counter and increments the counter. After writing address 4095 the state goes to IDLE and busy=0.
  - busy therefore falls exactly 4096 clocks after reset deasserts.
  - During CLEAR: wr_en is ignored (writes dropped, not queued) and rd_data = FILL_CHAR.
- A reset asserted mid-clear restarts the clear from address 0.
- A reset in IDLE does not wipe the RAM instantly; it re-enters CLEAR.

Optional Feature:
- Macro: TEXT_CHAR_BUFFER_CURSOR_EN.
- When defined, adds these ports:
  - cur_we  in  1
  - cur_data  in  12  {row[11:7]=v, col[6:0]=h}
  - cur_pos  out  12  {v, h}, reset value 0
  - blink  in  1
  - cursor  out  1
- cur_pos loads cur_data when cur_we=1.
- cursor is combinational: (rd_h==cur_h) && (rd_v==cur_v) && blink. It compares unscrolled screen coordinates.
- When the macro is not defined, these ports and registers are absent.

Decomposition:
- Package text_char_buffer_pkg holds:
  - H_BITS, V_BITS, depth constant
  - state enum {CLEAR, IDLE}
  - function pack_addr(h, v) returning {h, v}
- One sub-module, text_char_ram: synchronous single-port 4096x8 RAM (we, addr, din, registered dout), no reset on contents.

Test Plan:
- Clear: hold reset 3 cycles, release -> busy=1 for exactly 4096 clocks; afterwards a read of any cell with h<70 returns 8'h20.
- Write/read: write 8'h41 at wr_addr {row 5, col 10} (12'h28A) -> read rd_h=10, rd_v=5, line_offset=0 returns 8'h41 one clock later. During the write cycle rd_data is unchanged.
- Scroll wrap: write 8'h5A at row 1, col 0; set line_offset=3 -> read rd_v=30, rd_h=0 returns 8'h5A.
- Out-of-range column: write 8'h42 at col 100 -> read rd_h=100 returns 8'h20.
- Busy blocking: wr_en=1 with 8'h55 at cell (0,0) during CLEAR; after busy falls, (0,0) reads 8'h20. Reset mid-clear at count 2000 -> busy stays high 4096 clocks after release.
- Cursor (macro on): cur_data=12'h28A (row 5, col 10), blink=1, rd_h=10, rd_v=5 -> cursor=1. Same with blink=0 -> 0. rd_h=11 -> 0.

Source files
------------

// File: rtl/text_char_buffer_pkg.sv
// rtl/text_char_buffer_pkg.sv - shared geometry, state encoding and address packing for the text buffer
package text_char_buffer_pkg;

  localparam int H_BITS    = 7;
  localparam int V_BITS    = 5;
  localparam int A_BITS    = H_BITS + V_BITS;
  localparam int RAM_DEPTH = 1 << A_BITS;

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  // Source of the registered display output.
  typedef enum logic [1:0] {
    RD_ZERO,
    RD_FILL,
    RD_RAM
  } rd_sel_t;

  // Column occupies the high bits so one column's rows are contiguous.
  function automatic logic [A_BITS-1:0] pack_addr(input logic [H_BITS-1:0] h,
                                                  input logic [V_BITS-1:0] v);
    return {h, v};
  endfunction

endpackage

// File: rtl/text_char_ram.sv
// rtl/text_char_ram.sv - synchronous single-port character RAM, registered read, contents not reset
module text_char_ram
  import text_char_buffer_pkg::*;
#(
  parameter int AW = A_BITS,
  parameter int DW = 8
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // dout only moves on read cycles, so a write cycle leaves the last read visible.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= din;
    end else begin
      dout <= mem[addr];
    end
  end

endmodule

// File: rtl/text_char_buffer.sv
// rtl/text_char_buffer.sv - 128x32 character cell buffer with scroll and self-clear; cursor via TEXT_CHAR_BUFFER_CURSOR_EN
module text_char_buffer
  import text_char_buffer_pkg::*;
#(
  parameter int         COLS      = 70,
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [11:0]       wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [H_BITS-1:0] rd_h,
  input  logic [V_BITS-1:0] rd_v,
  output logic [7:0]        rd_data,
  input  logic              lo_we,
  input  logic [V_BITS-1:0] lo_data,
  output logic [V_BITS-1:0] line_offset,
  output logic              busy
`ifdef TEXT_CHAR_BUFFER_CURSOR_EN
  ,
  input  logic              cur_we,
  input  logic [11:0]       cur_data,
  output logic [11:0]       cur_pos,
  input  logic              blink,
  output logic              cursor
`endif
);

  localparam logic [H_BITS-1:0] COLS_L = H_BITS'(COLS);

  state_t              state;
  rd_sel_t             rd_sel;
  logic [A_BITS-1:0]   clr_cnt;
  logic [V_BITS-1:0]   phys_row;
  logic                ram_we;
  logic [A_BITS-1:0]   ram_addr;
  logic [7:0]          ram_din;
  logic [7:0]          ram_dout;

  // 5-bit add wraps the scrolled row around the 32-row store.
  assign phys_row = rd_v + line_offset;

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = pack_addr(rd_h, phys_row);
    ram_din  = 8'h00;
    if (reset) begin
      ram_we = 1'b0;
    end else if (state == CLEAR) begin
      ram_we   = 1'b1;
      ram_addr = clr_cnt;
      ram_din  = FILL_CHAR;
    end else if (wr_en) begin
      ram_we   = 1'b1;
      ram_addr = pack_addr(wr_addr[6:0], wr_addr[11:7]);
      ram_din  = wr_data;
    end
  end

  text_char_ram #(
    .AW (A_BITS),
    .DW (8)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .addr  (ram_addr),
    .din   (ram_din),
    .dout  (ram_dout)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= CLEAR;
      clr_cnt     <= '0;
      busy        <= 1'b1;
      rd_sel      <= RD_ZERO;
      line_offset <= '0;
    end else begin
      if (lo_we) begin
        line_offset <= lo_data;
      end
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          rd_sel  <= RD_FILL;
          if (clr_cnt == '1) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        IDLE: begin
          // A write cycle leaves the selector alone so rd_data holds.
          if (!wr_en) begin
            rd_sel <= (rd_h >= COLS_L) ? RD_FILL : RD_RAM;
          end
        end
        default: begin
          state <= CLEAR;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    case (rd_sel)
      RD_FILL: rd_data = FILL_CHAR;
      RD_RAM:  rd_data = ram_dout;
      default: rd_data = 8'h00;
    endcase
  end

`ifdef TEXT_CHAR_BUFFER_CURSOR_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      cur_pos <= '0;
    end else if (cur_we) begin
      cur_pos <= cur_data;
    end
  end

  // Compares raw screen coordinates; scrolling does not move the cursor.
  assign cursor = (rd_h == cur_pos[6:0]) && (rd_v == cur_pos[11:7]) && blink;
`endif

endmodule

// File: tb/tb_text_char_buffer.sv
// tb/tb_text_char_buffer.sv - scoreboard bench for text_char_buffer (cursor checks with TEXT_CHAR_BUFFER_CURSOR_EN)
module tb_text_char_buffer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [11:0] wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic [6:0]  rd_h = '0;
  logic [4:0]  rd_v = '0;
  logic [7:0]  rd_data;
  logic        lo_we = 1'b0;
  logic [4:0]  lo_data = '0;
  logic [4:0]  line_offset;
  logic        busy;
`ifdef TEXT_CHAR_BUFFER_CURSOR_EN
  logic        cur_we = 1'b0;
  logic [11:0] cur_data = '0;
  logic [11:0] cur_pos;
  logic        blink = 1'b0;
  logic        cursor;
`endif

  always #5 clock = ~clock;

  text_char_buffer dut (
    .clock       (clock),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_h        (rd_h),
    .rd_v        (rd_v),
    .rd_data     (rd_data),
    .lo_we       (lo_we),
    .lo_data     (lo_data),
    .line_offset (line_offset),
    .busy        (busy)
`ifdef TEXT_CHAR_BUFFER_CURSOR_EN
    ,
    .cur_we      (cur_we),
    .cur_data    (cur_data),
    .cur_pos     (cur_pos),
    .blink       (blink),
    .cursor      (cursor)
`endif
  );

  int         total = 0;
  int         bad = 0;
  int         tb_off = 0;
  logic [7:0] model [0:4095];
  logic [7:0] exp_q [$];
  logic [7:0] last_exp = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4096; i++) model[i] = 8'h20;
  endtask

  function automatic logic [7:0] model_rd(input int h, input int v);
    if (h >= 70) return 8'h20;
    return model[h * 32 + ((v + tb_off) % 32)];
  endfunction

  task automatic wr(input logic [11:0] a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en = 1'b0;
    model[int'(a[6:0]) * 32 + int'(a[11:7])] = d;
  endtask

  task automatic rd(input string tag, input int h, input int v);
    logic [7:0] e;
    rd_h = 7'(h);
    rd_v = 5'(v);
    exp_q.push_back(model_rd(h, v));
    tick();
    e = exp_q.pop_front();
    last_exp = e;
    check(tag, 32'(rd_data), 32'(e));
  endtask

  task automatic wait_busy(input string tag, input int start);
    int n;
    n = start;
    while (busy && n < 6000) begin
      tick();
      n++;
    end
    check(tag, n, 4096);
  endtask

  initial begin
    model_clear();
    repeat (3) tick();
    check("rst_busy", 32'(busy), 1);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_line_offset", 32'(line_offset), 0);

    // Release reset and try a write into (0,0) while the clear runs.
    reset   = 1'b0;
    wr_en   = 1'b1;
    wr_addr = 12'h000;
    wr_data = 8'h55;
    tick();
    wr_en = 1'b0;
    tick();
    check("clr_rd_fill", 32'(rd_data), 32'h20);
    check("clr_busy", 32'(busy), 1);
    wait_busy("clr_len", 2);
    model_clear();

    rd("clr_00_dropped", 0, 0);
    rd("clr_cell_69_31", 69, 31);
    rd("clr_cell_33_17", 33, 17);

    // Write cycle must not disturb the previous read result.
    wr(12'h28A, 8'h41);
    check("wr_hold", 32'(rd_data), 32'(last_exp));
    rd("wr_rd_10_5", 10, 5);

    wr(12'h080, 8'h5A);
    wr(12'h100, 8'h77);
    wr(12'hF05, 8'h66);
    lo_we   = 1'b1;
    lo_data = 5'd3;
    rd("lo_same_cycle_old", 0, 1);
    lo_we  = 1'b0;
    tb_off = 3;
    check("lo_value", 32'(line_offset), 3);
    rd("wrap_v30", 0, 30);
    rd("wrap_v31", 0, 31);
    rd("row30_stored", 5, 27);

    wr(12'h064, 8'h42);
    rd("oor_100", 100, 29);
    wr(12'h045, 8'h43);
    rd("col_69", 69, 29);
    rd("col_70", 70, 29);

    for (int i = 0; i < 8; i++) begin
      logic [11:0] a;
      logic [7:0]  d;
      a = 12'($urandom_range(0, 4095));
      d = 8'($urandom_range(0, 255));
      wr(a, d);
      rd("rand_rd", int'(a[6:0]), (int'(a[11:7]) - tb_off + 32) % 32);
    end

`ifdef TEXT_CHAR_BUFFER_CURSOR_EN
    cur_we   = 1'b1;
    cur_data = 12'h28A;
    tick();
    cur_we = 1'b0;
    check("cur_pos", 32'(cur_pos), 32'h28A);
    rd_h  = 7'd10;
    rd_v  = 5'd5;
    blink = 1'b1;
    #1;
    check("cursor_hit", 32'(cursor), 1);
    blink = 1'b0;
    #1;
    check("cursor_noblink", 32'(cursor), 0);
    blink = 1'b1;
    rd_h  = 7'd11;
    #1;
    check("cursor_miss", 32'(cursor), 0);
`endif

    // Reset in idle, then reset again mid-clear at count 2000.
    reset = 1'b1;
    tick();
    check("rst2_offset", 32'(line_offset), 0);
    reset = 1'b0;
    repeat (2000) tick();
    check("midclr_busy", 32'(busy), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_busy("midclr_len", 0);
    model_clear();
    tb_off = 0;
    rd("wiped_10_5", 10, 5);
    rd("wiped_0_1", 0, 1);

    check("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
